gpio_irq: RTL

//  Second-generation Wishbone B-4 GPIO: N tri-state pins with per-pin direction,

---
 rtl/gpio_irq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
// gpio_irq: Wishbone GPIO block with N tri-state pins, per-pin direction,
// atomic set/clear of output bits, a multi-stage input synchroniser and
// per-pin level/edge interrupts with sticky write-1-to-clear status.
//
// Ports
//   wb_clk_i   in   1      clock, everything on the rising edge
//   wb_rst_ni  in   1      asynchronous active-low reset
//   wb_adr_i   in   [4:2]  register word address
//   wb_dat_i   in   32     write data
//   wb_dat_o   out  32     read data, combinational from wb_adr_i
//   wb_we_i    in   1      write enable
//   wb_sel_i   in   4      byte lanes, honoured by every writable register
//   wb_stb_i   in   1      strobe (cyc already folded in)
//   wb_ack_o   out  1      acknowledge
//   irq_o      out  1      registered interrupt request
//   gpio_io    inout N     pads; a pin is driven when its DIR bit is 1
//
// Register map: 0 DAT, 1 DIR, 2 IE, 3 ITYPE, 4 IPOL, 5 ISTAT (W1C),
//               6 SET (write-only), 7 CLR (write-only).
//
// Handshake: a transfer is offered while wb_stb_i is high; wb_ack_o is
// registered as stb & !ack, so every access is acknowledged exactly one cycle
// after the strobe and a held strobe sees ack on alternate cycles. A write
// commits only on the edge where stb & we & !ack, so it never happens twice.
module gpio_irq #(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [4:2]   wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic         wb_we_i,
  input  logic [3:0]   wb_sel_i,
  input  logic         wb_stb_i,
  output logic         wb_ack_o,
  output logic         irq_o,
  inout  wire  [N-1:0] gpio_io
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [N-1:0] r_dat_out;
  logic [N-1:0] r_dir;
  logic [N-1:0] r_ie;
  logic [N-1:0] r_itype;
  logic [N-1:0] r_ipol;
  logic [N-1:0] r_istat;
  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] r_prev;
  logic [2:0]   r_warm;

  logic [N-1:0] w_sync;
  logic [31:0]  w_bmask32;
  logic [N-1:0] w_wmask;
  logic [N-1:0] w_wdat;
  logic [N-1:0] w_wbits;
  logic         w_wr;
  logic         w_warm_done;
  logic [N-1:0] w_level_ev;
  logic [N-1:0] w_edge_ev;
  logic [N-1:0] w_event;
  logic [N-1:0] w_clr;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_bmask32   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                        {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wmask     = w_bmask32[N-1:0];
  assign w_wdat      = wb_dat_i[N-1:0];
  assign w_wbits     = w_wdat & w_wmask;
  assign w_wr        = wb_stb_i & wb_we_i & ~wb_ack_o;
  assign w_warm_done = (r_warm == WARM_DONE);

  // Level event: pin equals its active polarity. Edge event: pin just changed
  // and landed on the polarity. Edge events are held off during warm-up so a
  // pin that was already high at reset release is not mistaken for a rise.
  assign w_level_ev = ~(w_sync ^ r_ipol);
  assign w_edge_ev  = (w_sync ^ r_prev) & w_level_ev & {N{w_warm_done}};
  assign w_event    = (r_itype & w_edge_ev) | (~r_itype & w_level_ev);
  assign w_clr      = (w_wr && wb_adr_i == 3'd5) ? w_wbits : '0;

  // Bus acknowledge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
    end else begin
      wb_ack_o <= wb_stb_i & ~wb_ack_o;
    end
  end

  // Configuration and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_dat_out <= '0;
      r_dir     <= '0;
      r_ie      <= '0;
      r_itype   <= '0;
      r_ipol    <= '0;
    end else if (w_wr) begin
      case (wb_adr_i)
        3'd0: r_dat_out <= (r_dat_out & ~w_wmask) | w_wbits;
        3'd1: r_dir     <= (r_dir     & ~w_wmask) | w_wbits;
        3'd2: r_ie      <= (r_ie      & ~w_wmask) | w_wbits;
        3'd3: r_itype   <= (r_itype   & ~w_wmask) | w_wbits;
        3'd4: r_ipol    <= (r_ipol    & ~w_wmask) | w_wbits;
        3'd6: r_dat_out <= r_dat_out | w_wbits;
        3'd7: r_dat_out <= r_dat_out & ~w_wbits;
        default: ;
      endcase
    end
  end

  // Input synchroniser, previous sample and warm-up counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync[0] <= gpio_io;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_sync;
      if (!w_warm_done) r_warm <= r_warm + 3'd1;
    end
  end

  // Sticky status: a new event on the same edge as a W1C keeps the bit set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_istat <= '0;
      irq_o   <= 1'b0;
    end else begin
      r_istat <= (r_istat & ~w_clr) | (w_event & r_ie);
      irq_o   <= |(r_istat & r_ie);
    end
  end

  // Read mux; bits at and above N read as zero.
  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      3'd0: wb_dat_o[N-1:0] = w_sync;
      3'd1: wb_dat_o[N-1:0] = r_dir;
      3'd2: wb_dat_o[N-1:0] = r_ie;
      3'd3: wb_dat_o[N-1:0] = r_itype;
      3'd4: wb_dat_o[N-1:0] = r_ipol;
      3'd5: wb_dat_o[N-1:0] = r_istat;
      default: ;
    endcase
  end

  // Pad drivers
  for (genvar g = 0; g < N; g++) begin : g_pad
    assign gpio_io[g] = r_dir[g] ? r_dat_out[g] : 1'bz;
  end

endmodule
